// File: rtl/button_pkg.sv
// Shared constants for the board push-button / mode-switch front end.
// Button indices name the bit positions of the buttons bus.
package button_pkg;

  localparam int unsigned NUM_BUTTONS_DEFAULT     = 5;
  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 250000;
  localparam int unsigned DEBOUNCE_CYCLES_SIM     = 4;

  localparam int unsigned BTN_CENTER = 0;
  localparam int unsigned BTN_UP     = 1;
  localparam int unsigned BTN_LEFT   = 2;
  localparam int unsigned BTN_RIGHT  = 3;
  localparam int unsigned BTN_DOWN   = 4;

endpackage

// File: rtl/debounce_channel.sv
// One conditioning channel: 2-flop synchronizer, stability counter, accepted
// level and a one-cycle pulse on each accepted rising level.
module debounce_channel #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             stable;
  logic [CNT_W-1:0] cnt;
  logic             press_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      stable  <= 1'b0;
      cnt     <= '0;
      press_q <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      // Any return to the accepted level throws away the partial count.
      if (sync2 == stable) begin
        cnt     <= '0;
        press_q <= 1'b0;
      end else if (cnt == CNT_LAST) begin
        stable  <= sync2;
        cnt     <= '0;
        press_q <= sync2;
      end else begin
        cnt     <= cnt + CNT_W'(1);
        press_q <= 1'b0;
      end
    end
  end

  assign level = stable;
  assign rise  = press_q;

endmodule

// File: rtl/button_conditioner.sv
// Conditions the raw buttons and mode switch into clean registered levels
// plus per-button press pulses for mux_control.
module button_conditioner
  import button_pkg::*;
#(
  parameter int unsigned NUM_BUTTONS     = NUM_BUTTONS_DEFAULT,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_BUTTONS-1:0] btn_raw,
  input  logic                   sw_raw,
  output logic [NUM_BUTTONS-1:0] buttons,
  output logic                   switch,
  output logic [NUM_BUTTONS-1:0] btn_press
);

  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_btn
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn (
      .clk  (clk),
      .reset(reset),
      .raw  (btn_raw[i]),
      .level(buttons[i]),
      .rise (btn_press[i])
    );
  end

  // The switch has no press consumer, so its pulse is left open.
  debounce_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_sw (
    .clk  (clk),
    .reset(reset),
    .raw  (sw_raw),
    .level(switch),
    .rise ()
  );

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner: a window-based reference model
// predicts every cycle's outputs, a monitor compares them on the falling edge.
module tb_button_conditioner;
  import button_pkg::*;

  localparam int NB = 5;
  localparam int DC = int'(DEBOUNCE_CYCLES_SIM);

  logic          clk = 1'b0;
  logic          reset;
  logic [NB-1:0] btn_raw;
  logic          sw_raw;
  logic [NB-1:0] buttons;
  logic          switch;
  logic [NB-1:0] btn_press;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [NB-1:0] b;
    logic          s;
    logic [NB-1:0] p;
  } exp_t;

  exp_t expq[$];

  button_conditioner #(
    .NUM_BUTTONS    (NB),
    .DEBOUNCE_CYCLES(DC)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .btn_raw  (btn_raw),
    .sw_raw   (sw_raw),
    .buttons  (buttons),
    .switch   (switch),
    .btn_press(btn_press)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", nm, got, exp, $time);
    end
  endtask

  // Reference model: a channel flips its accepted level when the last
  // DC synchronized samples (raw two edges old) all disagree with it.
  initial begin : model
    logic [NB:0] hist [0:DC];
    logic [NB:0] ms;
    logic [NB:0] pr;
    logic        diff;
    exp_t        e;
    for (int j = 0; j <= DC; j++) hist[j] = '0;
    ms = '0;
    forever begin
      @(posedge clk);
      if (reset !== 1'b1) begin
        for (int j = 0; j <= DC; j++) hist[j] = '0;
        ms = '0;
        e  = '0;
      end else begin
        pr = '0;
        for (int b = 0; b <= NB; b++) begin
          diff = 1'b1;
          for (int j = 1; j <= DC; j++)
            if (hist[j][b] == ms[b]) diff = 1'b0;
          if (diff) begin
            ms[b] = ~ms[b];
            pr[b] = ms[b];
          end
        end
        for (int j = DC; j >= 1; j--) hist[j] = hist[j-1];
        hist[0] = {sw_raw, btn_raw};
        e.b = ms[NB-1:0];
        e.s = ms[NB];
        e.p = pr[NB-1:0];
      end
      expq.push_back(e);
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("scoreboard", 16'({buttons, switch, btn_press}), 16'({e.b, e.s, e.p}));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin : stim
    int pulses;
    int when;
    reset   = 1'b0;
    btn_raw = 5'h1F;
    sw_raw  = 1'b1;
    #1;
    chk("reset_async_zero", 16'({buttons, switch, btn_press}), 16'h0);
    step(5);
    chk("reset_hold_zero", 16'({buttons, switch, btn_press}), 16'h0);
    reset = 1'b1;
    step(5);
    chk("reset_release_early", 16'({buttons, switch}), 16'h0);
    step(1);
    chk("reset_release_rise", 16'({buttons, switch, btn_press}), 16'({5'h1F, 1'b1, 5'h1F}));
    step(1);
    chk("reset_release_pulse_end", 16'(btn_press), 16'h0);

    // Clean press on a quiet bus.
    btn_raw = 5'h00;
    sw_raw  = 1'b0;
    step(8);
    btn_raw = 5'h01;
    step(5);
    chk("clean_not_early", 16'(buttons), 16'h00);
    step(1);
    chk("clean_level", 16'(buttons), 16'h01);
    chk("clean_pulse", 16'(btn_press), 16'h01);
    step(1);
    chk("clean_pulse_end", 16'({buttons, btn_press}), 16'({5'h01, 5'h00}));

    // Bounce on button 1, then hold high.
    btn_raw[1] = 1'b1; step(1);
    btn_raw[1] = 1'b0; step(1);
    btn_raw[1] = 1'b1; step(1);
    btn_raw[1] = 1'b0; step(1);
    chk("bounce_no_change", 16'(buttons), 16'h01);
    btn_raw[1] = 1'b1;
    pulses = 0;
    when   = 0;
    for (int i = 1; i <= 10; i++) begin
      step(1);
      if (btn_press[1]) begin
        pulses++;
        when = i;
      end
    end
    chk("bounce_pulse_count", 16'(pulses), 16'd1);
    chk("bounce_pulse_time", 16'(when), 16'd6);

    // Switch glitch shorter than the debounce window.
    sw_raw = 1'b1; step(3);
    sw_raw = 1'b0; step(10);
    chk("glitch_rejected", 16'(switch), 16'h0);
    sw_raw = 1'b1; step(4);
    sw_raw = 1'b0; step(2);
    chk("four_cycle_accepted", 16'(switch), 16'h1);
    step(10);

    // Simultaneous and independent transitions.
    btn_raw = 5'h00;
    step(10);
    btn_raw = 5'h17;
    step(6);
    chk("simul_press", 16'(btn_press), 16'h17);
    step(4);
    btn_raw = 5'h0C;
    step(6);
    chk("indep_level", 16'(buttons), 16'h0C);
    chk("indep_press", 16'(btn_press), 16'h08);
    step(4);

    // Reset in the middle of a pending press.
    btn_raw = 5'h0D;
    step(2);
    #2 reset = 1'b0;
    #1;
    chk("midcount_async_zero", 16'({buttons, switch, btn_press}), 16'h0);
    step(3);
    reset = 1'b1;
    step(5);
    chk("midcount_not_early", 16'(buttons), 16'h00);
    step(1);
    chk("midcount_repress", 16'({buttons, btn_press}), 16'({5'h0D, 5'h0D}));
    step(1);
    chk("midcount_pulse_end", 16'(btn_press), 16'h00);

    // Randomized holds, with an occasional asynchronous reset pulse.
    for (int it = 0; it < 400; it++) begin
      btn_raw = NB'($urandom);
      sw_raw  = 1'($urandom);
      if ($urandom_range(0, 39) == 0) begin
        #2 reset = 1'b0;
        step(2);
        reset = 1'b1;
      end
      step($urandom_range(1, 7));
    end
    step(12);
    chk("queue_drained", 16'(expq.size()), 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
# button_conditioner

Front-end conditioner for the board's raw push-buttons and mode switch, and the producer side of the `buttons`/`switch` interface that `mux_control` consumes. Each raw input is synchronized into `clk`, debounced with a per-channel stability counter, and presented as a clean registered level. Each button also gets a single-cycle press pulse. The switch and the buttons use identical conditioning, so `mux_control` never sees metastable, bouncing or sub-threshold glitching inputs.

## Interface
- `NUM_BUTTONS`, default 5: number of button channels; must match `mux_control`'s `buttons` width.
- `DEBOUNCE_CYCLES`, default 250000: consecutive stable cycles required to accept a new level. Legal minimum is 2; benches use 4.
- `clk` input, 1 bit: single system clock. All logic is on its rising edge.
- `reset` input, 1 bit: asynchronous, active-low reset (asserted when 0), released synchronously by the integrator.
- `btn_raw` input, NUM_BUTTONS bits: raw, asynchronous, bouncing button levels, active-high.
- `sw_raw` input, 1 bit: raw, asynchronous mode switch level.
- `buttons` output, NUM_BUTTONS bits: debounced button levels; feeds `mux_control.buttons`.
- `switch` output, 1 bit: debounced switch level; feeds `mux_control.switch`.
- `btn_press` output, NUM_BUTTONS bits: one-cycle pulse per bit on each accepted 0→1 transition of `buttons`.

## Operation
- There are NUM_BUTTONS+1 independent channels: one per button bit, plus one for the switch, which has its press output left unused.
- Per-channel registers:
  - `sync1`, `sync2`: 2-flop synchronizer.
  - `stable`: the accepted level.
  - `cnt`: width clog2(DEBOUNCE_CYCLES+1).
  - `press_q`.
- Each cycle: `sync1 <= raw`, `sync2 <= sync1`.
- If `sync2 == stable`: `cnt <= 0`, `press_q <= 0`.
- If `sync2 != stable` and `cnt < DEBOUNCE_CYCLES-1`: `cnt <= cnt+1`, `press_q <= 0`.
- If `sync2 != stable` and `cnt == DEBOUNCE_CYCLES-1`: `stable <= sync2`, `cnt <= 0`, `press_q <= sync2`. `press_q` is 1 only on acceptance of a rising level.
- A glitch or bounce that returns to `stable` before the count completes clears `cnt`; no output change occurs and no partial credit carries over.
- Channels are fully independent. Simultaneous transitions on any set of bits each resolve on their own counters; bits that change in the same cycle are accepted in the same cycle.
- Outputs map directly from registers: `buttons[i] = stable_i`, `switch = stable_sw`, `btn_press[i] = press_q_i`. There is no combinational path from input to output.
- No release pulse is generated, and there is no auto-repeat while a button is held.

## Timing
- Reset (`reset == 0`, asynchronous): all `sync1`, `sync2`, `stable`, `cnt` and `press_q` clear to 0. `buttons = 0`, `switch = 0`, `btn_press = 0` immediately, with no clock needed.
- Reset asserted mid-count: the count is discarded. After release, a raw input that is already high is re-accepted from scratch. If that input is a button, it produces a fresh `btn_press` pulse.
- Latency: a raw level sampled at edge k is accepted, and `buttons`/`btn_press` update, after edge k+1+DEBOUNCE_CYCLES. This assumes the raw level is held steady throughout.
- `btn_press` is high for exactly one cycle, coincident with the first cycle of `buttons` high.
- Minimum accepted pulse width: DEBOUNCE_CYCLES cycles of steady synchronized level. Shorter pulses are always rejected.
- A release followed by a re-press yields a second pulse only if the low level is itself accepted first, meaning it stays low for ≥ DEBOUNCE_CYCLES cycles.

## Structure
- Shared package `button_pkg`:
  - `NUM_BUTTONS_DEFAULT` (5).
  - `DEBOUNCE_CYCLES_DEFAULT` (250000).
  - `DEBOUNCE_CYCLES_SIM` (4).
  - Button index constants `BTN_CENTER`, `BTN_UP`, `BTN_LEFT`, `BTN_RIGHT`, `BTN_DOWN` (0–4).
- One natural sub-module, `debounce_channel`:
  - Parameter `DEBOUNCE_CYCLES`.
  - Ports `clk`, `reset`, `raw`, `level`, `rise`.
  - Instantiated NUM_BUTTONS times through a generate loop, plus once for the switch.
- Top level contains only instantiation and wiring. Its testbench instantiates it alongside `mux_control` in an end-to-end bench.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and a 10-time-unit clock.
- Reset: hold `reset=0` with `btn_raw=5'h1F`, `sw_raw=1`. Required: `buttons=0`, `switch=0`, `btn_press=0` throughout. After release, all bits rise together at edge 6 after release and `btn_press=5'h1F` for one cycle.
- Clean press: `btn_raw=5'h01` held from edge k. Required: `buttons=5'h01` and `btn_press=5'h01` after edge k+5. `btn_press` returns to 0 next cycle and `buttons` stays high.
- Bounce: `btn_raw[1]` toggles 1,0,1,0 each cycle, then holds 1. Required: no output change during toggling; exactly one `btn_press[1]` pulse, 5 edges after the hold begins.
- Glitch rejection: `sw_raw` high for 3 cycles, then back low. Required: `switch` stays 0. A subsequent 4-cycle-held high is accepted.
- Simultaneous/independent: `btn_raw` changes 5'h00→5'h17. Required: `btn_press=5'h17` in a single cycle. Then 5'h17→5'h0C gives `buttons=5'h0C` and `btn_press=5'h08` only.
- Reset mid-count: assert `reset=0` two cycles into an accepted-pending press. Required: outputs are 0 instantly. After release with input still high, the press is accepted 5 edges later with one pulse.
